// File: rtl/tone_gen_if.sv
// -----------------------------------------------------------------------------
// tone_gen_if
// Bundles the request, configuration and sample-stream signals of tone_gen.
//   master : drives sample_en, ch_enable and the cfg_* write/select lines,
//            receives cfg_rdata, the output sample stream, busy and overrun.
//   slave  : the tone generator side (directions mirrored).
// Parameters must match the ones given to the tone_gen instance.
// -----------------------------------------------------------------------------
interface tone_gen_if #(
    parameter int CHANNELS = 2,
    parameter int PHASE_W  = 32,
    parameter int OUT_W    = 16
);
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                sample_en;
    logic                cfg_we;
    logic [CH_W-1:0]     cfg_ch;
    logic [1:0]          cfg_addr;
    logic [PHASE_W-1:0]  cfg_wdata;
    logic [PHASE_W-1:0]  cfg_rdata;
    logic [CHANNELS-1:0] ch_enable;
    logic                out_valid;
    logic [CH_W-1:0]     out_ch;
    logic [OUT_W-1:0]    out_data;
    logic                busy;
    logic                overrun;

    modport master (
        output sample_en, cfg_we, cfg_ch, cfg_addr, cfg_wdata, ch_enable,
        input  cfg_rdata, out_valid, out_ch, out_data, busy, overrun
    );

    modport slave (
        input  sample_en, cfg_we, cfg_ch, cfg_addr, cfg_wdata, ch_enable,
        output cfg_rdata, out_valid, out_ch, out_data, busy, overrun
    );
endinterface

// File: rtl/tone_gen.sv
// -----------------------------------------------------------------------------
// tone_gen
// Multi-channel sine tone generator built on a quarter-wave lookup table.
// A sample_en pulse starts a burst that walks the channels in ascending
// order, one per cycle, through a three-stage pipeline:
//   stage 1 : quadrant/index from the channel phase, table read issued,
//             phase advanced and optional frequency sweep applied
//   stage 2 : registered table value available, sign applied, amplitude
//             scaling computed
//   stage 3 : registered sample on out_data/out_ch with out_valid
// Ports:
//   clk   - single clock, rising edge
//   reset - synchronous, active high
//   bus   - tone_gen_if.slave: sample_en, ch_enable, cfg_* register port
//           (registered readback), out_valid/out_ch/out_data, busy, overrun
// -----------------------------------------------------------------------------
module tone_gen #(
    parameter int CHANNELS = 2,
    parameter int PHASE_W  = 32,
    parameter int OUT_W    = 16,
    parameter int LUT_AW   = 8
) (
    input  logic        clk,
    input  logic        reset,
    tone_gen_if.slave   bus
);
    localparam int              CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int              LUT_N   = 1 << LUT_AW;
    localparam int              PROD_W  = OUT_W + 18;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNELS - 1);

    // Quarter-wave entry k = round((2^(OUT_W-1)-1) * sin(pi/2*(k+0.5)/LUT_N)).
    // The half-step offset keeps the table symmetric so the other three
    // quadrants are pure index inversion and negation.
    function automatic logic [OUT_W-1:0] lut_entry(input int k);
        real x;
        real term;
        real sum;
        real peak;
        x    = 3.14159265358979323846 / 2.0 * (real'(k) + 0.5) / real'(LUT_N);
        term = x;
        sum  = x;
        for (int n = 1; n < 12; n++) begin
            term = -term * x * x / real'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        peak = (2.0 ** (OUT_W - 1) - 1.0) * sum;
        return OUT_W'(int'(peak));
    endfunction

    // Read views of the per-channel register files
    logic [LUT_AW+1:0]  top_arr  [CHANNELS];
    logic [PHASE_W-1:0] inc_arr  [CHANNELS];
    logic [15:0]        amp_arr  [CHANNELS];
    logic [PHASE_W-1:0] step_arr [CHANNELS];
    logic [PHASE_W-1:0] end_arr  [CHANNELS];

    // Sine table (read through a registered port)
    logic [OUT_W-1:0]   lut_rom  [LUT_N];

    // Burst sequencing
    logic               busy_q, busy_d;
    logic               overrun_q, overrun_d;
    logic               s1_active_q, s1_active_d;
    logic [CH_W-1:0]    s1_ch_q, s1_ch_d;
    logic               accept;

    // Stage 1 decode
    logic [LUT_AW+1:0]  s1_top;
    logic [1:0]         s1_quad;
    logic [LUT_AW-1:0]  s1_idx;
    logic [15:0]        s1_amp;
    logic [15:0]        s1_amp_c;
    logic               s1_en;

    // Stage 2 registers
    logic               s2_valid_q;
    logic [CH_W-1:0]    s2_ch_q;
    logic               s2_neg_q;
    logic               s2_en_q;
    logic [15:0]        s2_amp_q;
    logic [OUT_W-1:0]   lut_q;

    // Stage 2 arithmetic
    logic signed [OUT_W-1:0]  s3_sample;
    logic signed [PROD_W-1:0] s3_prod;
    logic [OUT_W-1:0]         s3_data;

    // Output registers
    logic               out_valid_q;
    logic [CH_W-1:0]    out_ch_q;
    logic [OUT_W-1:0]   out_data_q;
    logic [PHASE_W-1:0] cfg_rdata_q, cfg_rdata_d;

    genvar gi;

    generate
        for (gi = 0; gi < LUT_N; gi++) begin : g_lut
            assign lut_rom[gi] = lut_entry(gi);
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Per-channel register files: phase, inc, amp, sweep_step, sweep_end
    // -------------------------------------------------------------------------
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [PHASE_W-1:0] phase_q;
            logic [PHASE_W-1:0] inc_q;
            logic [15:0]        amp_q;
            logic [PHASE_W-1:0] step_q;
            logic [PHASE_W-1:0] end_q;
            logic [PHASE_W:0]   sweep_sum;
            logic [PHASE_W-1:0] sweep_inc;
            logic               s1_hit;
            logic               wr_hit;

            assign s1_hit    = s1_active_q && (s1_ch_q == CH_W'(gi));
            assign wr_hit    = bus.cfg_we && (bus.cfg_ch == CH_W'(gi));
            assign sweep_sum = {1'b0, inc_q} + {1'b0, step_q};

            // Sweep only moves inc toward sweep_end; a carry out of the add
            // means the true sum is beyond any representable end value.
            always_comb begin
                sweep_inc = inc_q;
                if ((step_q != '0) && (inc_q < end_q)) begin
                    if (sweep_sum[PHASE_W] || (sweep_sum[PHASE_W-1:0] > end_q)) begin
                        sweep_inc = end_q;
                    end else begin
                        sweep_inc = sweep_sum[PHASE_W-1:0];
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    phase_q <= '0;
                    inc_q   <= '0;
                    amp_q   <= '0;
                    step_q  <= '0;
                    end_q   <= '0;
                end else begin
                    // A disabled channel restarts from phase 0 when re-enabled
                    if (s1_hit) begin
                        phase_q <= bus.ch_enable[gi] ? (phase_q + inc_q) : '0;
                    end
                    // A host write to inc overrides the sweep in the same cycle
                    if (wr_hit && (bus.cfg_addr == 2'd0)) begin
                        inc_q <= bus.cfg_wdata;
                    end else if (s1_hit && bus.ch_enable[gi]) begin
                        inc_q <= sweep_inc;
                    end
                    if (wr_hit && (bus.cfg_addr == 2'd1)) begin
                        amp_q <= bus.cfg_wdata[15:0];
                    end
                    if (wr_hit && (bus.cfg_addr == 2'd2)) begin
                        step_q <= bus.cfg_wdata;
                    end
                    if (wr_hit && (bus.cfg_addr == 2'd3)) begin
                        end_q <= bus.cfg_wdata;
                    end
                end
            end

            assign top_arr[gi]  = phase_q[PHASE_W-1 -: LUT_AW+2];
            assign inc_arr[gi]  = inc_q;
            assign amp_arr[gi]  = amp_q;
            assign step_arr[gi] = step_q;
            assign end_arr[gi]  = end_q;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Burst sequencing
    // -------------------------------------------------------------------------
    assign accept = bus.sample_en && !busy_q;

    always_comb begin
        s1_active_d = s1_active_q;
        s1_ch_d     = s1_ch_q;
        busy_d      = busy_q;
        overrun_d   = overrun_q | (bus.sample_en & busy_q);

        if (accept) begin
            s1_active_d = 1'b1;
            s1_ch_d     = '0;
            busy_d      = 1'b1;
        end else begin
            if (s1_active_q) begin
                if (s1_ch_q == LAST_CH) begin
                    s1_active_d = 1'b0;
                end else begin
                    s1_ch_d = s1_ch_q + CH_W'(1);
                end
            end
            // busy covers the cycle of the last sample, then drops
            if (out_valid_q && (out_ch_q == LAST_CH)) begin
                busy_d = 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stage 1: quadrant folding into the quarter-wave table
    // -------------------------------------------------------------------------
    assign s1_top   = top_arr[s1_ch_q];
    assign s1_quad  = s1_top[LUT_AW+1 -: 2];
    assign s1_idx   = s1_quad[0] ? ~s1_top[LUT_AW-1:0] : s1_top[LUT_AW-1:0];
    assign s1_amp   = amp_arr[s1_ch_q];
    assign s1_amp_c = (s1_amp > 16'h8000) ? 16'h8000 : s1_amp;
    assign s1_en    = bus.ch_enable[s1_ch_q];

    always_ff @(posedge clk) begin
        lut_q <= lut_rom[s1_idx];
    end

    // -------------------------------------------------------------------------
    // Stage 2: sign and amplitude. Amplitude is at most 2^15, so the shifted
    // product always fits back into OUT_W bits.
    // -------------------------------------------------------------------------
    assign s3_sample = s2_neg_q ? -$signed(lut_q) : $signed(lut_q);
    assign s3_prod   = PROD_W'(s3_sample) * PROD_W'($signed({2'b00, s2_amp_q}));
    assign s3_data   = s2_en_q ? OUT_W'(s3_prod >>> 15) : '0;

    // -------------------------------------------------------------------------
    // Config readback mux
    // -------------------------------------------------------------------------
    always_comb begin
        cfg_rdata_d = '0;
        if (int'(bus.cfg_ch) < CHANNELS) begin
            case (bus.cfg_addr)
                2'd0:    cfg_rdata_d = inc_arr[bus.cfg_ch];
                2'd1:    cfg_rdata_d = PHASE_W'(amp_arr[bus.cfg_ch]);
                2'd2:    cfg_rdata_d = step_arr[bus.cfg_ch];
                default: cfg_rdata_d = end_arr[bus.cfg_ch];
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Pipeline and status registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            s1_active_q <= 1'b0;
            s1_ch_q     <= '0;
            s2_valid_q  <= 1'b0;
            s2_ch_q     <= '0;
            s2_neg_q    <= 1'b0;
            s2_en_q     <= 1'b0;
            s2_amp_q    <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_data_q  <= '0;
            cfg_rdata_q <= '0;
        end else begin
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
            s1_active_q <= s1_active_d;
            s1_ch_q     <= s1_ch_d;
            s2_valid_q  <= s1_active_q;
            s2_ch_q     <= s1_ch_q;
            s2_neg_q    <= s1_quad[1];
            s2_en_q     <= s1_en;
            s2_amp_q    <= s1_amp_c;
            out_valid_q <= s2_valid_q;
            out_ch_q    <= s2_valid_q ? s2_ch_q : '0;
            out_data_q  <= s2_valid_q ? s3_data : '0;
            cfg_rdata_q <= cfg_rdata_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.overrun   = overrun_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_data  = out_data_q;
    assign bus.cfg_rdata = cfg_rdata_q;
endmodule

// File: tb/tb_tone_gen.sv
// -----------------------------------------------------------------------------
// tb_tone_gen
// Self-checking bench for tone_gen. A reference model holds each channel's
// registers as plain integers and computes samples directly from the sine
// formula with real arithmetic; directed scenarios are followed by
// randomized configuration and burst traffic.
// -----------------------------------------------------------------------------
module tb_tone_gen;
    localparam int CH  = 2;
    localparam int PW  = 32;
    localparam int OW  = 16;
    localparam int AW  = 8;
    localparam int CHW = 1;
    localparam longint MASK = (longint'(1) << PW) - 1;
    localparam real PI = 3.14159265358979323846;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    tone_gen_if #(.CHANNELS(CH), .PHASE_W(PW), .OUT_W(OW)) bus ();

    tone_gen #(.CHANNELS(CH), .PHASE_W(PW), .OUT_W(OW), .LUT_AW(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    longint m_phase [CH];
    longint m_inc   [CH];
    longint m_amp   [CH];
    longint m_step  [CH];
    longint m_end   [CH];
    bit     m_overrun;
    longint last_out [CH];

    task automatic check_val(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint ref_sample(input longint ph, input longint amp);
        longint q, idx, s, a;
        real v;
        q   = (ph >> (PW - 2)) & 3;
        idx = (ph >> (PW - 2 - AW)) & ((longint'(1) << AW) - 1);
        if (q == 1 || q == 3) idx = (longint'(1) << AW) - 1 - idx;
        v = (2.0 ** (OW - 1) - 1.0) * $sin(PI / 2.0 * (real'(idx) + 0.5) / (2.0 ** AW));
        s = longint'(v);
        if (q >= 2) s = -s;
        a = (amp > 32768) ? 32768 : amp;
        return longint'($floor(real'(s * a) / 32768.0));
    endfunction

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_phase[c] = 0; m_inc[c] = 0; m_amp[c] = 0; m_step[c] = 0; m_end[c] = 0;
        end
        m_overrun = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic cfg_write(input int ch, input int addr, input longint data);
        @(negedge clk);
        bus.cfg_we    = 1'b1;
        bus.cfg_ch    = ch[CHW-1:0];
        bus.cfg_addr  = addr[1:0];
        bus.cfg_wdata = data[PW-1:0];
        case (addr)
            0:       m_inc[ch]  = data & MASK;
            1:       m_amp[ch]  = data & 16'hFFFF;
            2:       m_step[ch] = data & MASK;
            default: m_end[ch]  = data & MASK;
        endcase
        @(negedge clk);
        bus.cfg_we = 1'b0;
    endtask

    task automatic cfg_read_check(input int ch, input int addr, input string tag);
        longint exp;
        case (addr)
            0:       exp = m_inc[ch];
            1:       exp = m_amp[ch];
            2:       exp = m_step[ch];
            default: exp = m_end[ch];
        endcase
        @(negedge clk);
        bus.cfg_ch   = ch[CHW-1:0];
        bus.cfg_addr = addr[1:0];
        @(negedge clk);
        check_val(tag, longint'(bus.cfg_rdata), exp);
    endtask

    // One burst; dup re-requests at T+2, wr_inc >= 0 writes ch0 inc while
    // ch0 is in its first pipeline cycle.
    task automatic run_burst(input logic [CH-1:0] en, input bit dup,
                             input longint wr_inc, input string tag);
        longint exp_d [CH];
        for (int c = 0; c < CH; c++) begin
            if (en[c]) begin
                exp_d[c]   = ref_sample(m_phase[c], m_amp[c]);
                m_phase[c] = (m_phase[c] + m_inc[c]) & MASK;
                if (m_step[c] != 0 && m_inc[c] < m_end[c])
                    m_inc[c] = (m_inc[c] + m_step[c] > m_end[c]) ? m_end[c] : m_inc[c] + m_step[c];
            end else begin
                exp_d[c]   = 0;
                m_phase[c] = 0;
            end
        end
        if (wr_inc >= 0) m_inc[0] = wr_inc;
        @(negedge clk);
        bus.ch_enable = en;
        bus.sample_en = 1'b1;
        for (int k = 1; k <= CH + 3; k++) begin
            @(negedge clk);
            check_val({tag, "_busy"}, longint'(bus.busy), longint'(k <= CH + 2));
            check_val({tag, "_valid"}, longint'(bus.out_valid), longint'(k >= 3 && k <= CH + 2));
            if (k >= 3 && k <= CH + 2) begin
                check_val({tag, "_ch"}, longint'(bus.out_ch), longint'(k - 3));
                check_val({tag, "_data"}, longint'($signed(bus.out_data)), exp_d[k-3]);
                last_out[k-3] = longint'($signed(bus.out_data));
            end
            bus.sample_en = dup && (k == 2);
            if (wr_inc >= 0) begin
                bus.cfg_we = (k == 1);
                if (k == 1) begin
                    bus.cfg_ch    = '0;
                    bus.cfg_addr  = 2'd0;
                    bus.cfg_wdata = wr_inc[PW-1:0];
                end
            end
        end
        if (dup) m_overrun = 1;
        check_val({tag, "_ovr"}, longint'(bus.overrun), longint'(m_overrun));
    endtask

    task automatic random_round();
        int nw, c, a;
        longint d;
        nw = $urandom_range(1, 3);
        for (int w = 0; w < nw; w++) begin
            c = $urandom_range(0, CH - 1);
            a = $urandom_range(0, 3);
            case (a)
                1:       d = $urandom_range(0, 65535);
                2:       d = ($urandom_range(0, 1) == 1) ? 0 : longint'($urandom());
                default: d = longint'($urandom());
            endcase
            cfg_write(c, a, d);
        end
        run_burst(CH'($urandom_range(0, (1 << CH) - 1)), 0, -1, "rnd");
        cfg_read_check($urandom_range(0, CH - 1), $urandom_range(0, 3), "rnd_rd");
    endtask

    longint e34 [4] = '{101, 32767, -101, -32767};
    longint e35 [4] = '{50, 16383, -51, -16384};
    longint e37 [5] = '{32'h02000000, 32'h03000000, 32'h03000000, 32'h03000000, 32'h03000000};

    initial begin
        reset         = 1'b1;
        bus.sample_en = 1'b0;
        bus.cfg_we    = 1'b0;
        bus.cfg_ch    = '0;
        bus.cfg_addr  = '0;
        bus.cfg_wdata = '0;
        bus.ch_enable = '0;
        model_reset();
        repeat (4) @(negedge clk);
        reset = 1'b0;

        // Idle after reset
        repeat (10) @(negedge clk);
        check_val("idle_valid", longint'(bus.out_valid), 0);
        check_val("idle_ch",    longint'(bus.out_ch), 0);
        check_val("idle_data",  longint'(bus.out_data), 0);
        check_val("idle_busy",  longint'(bus.busy), 0);
        check_val("idle_ovr",   longint'(bus.overrun), 0);
        check_val("idle_rdata", longint'(bus.cfg_rdata), 0);
        for (int c = 0; c < CH; c++)
            for (int a = 0; a < 4; a++)
                cfg_read_check(c, a, "idle_reg");

        // Quadrant walk at full amplitude, ch1 disabled
        cfg_write(0, 0, 32'h40000000);
        cfg_write(0, 1, 32768);
        for (int b = 0; b < 4; b++) begin
            run_burst(2'b01, 0, -1, "quad");
            check_val("quad_ch0", last_out[0], e34[b]);
            check_val("quad_ch1", last_out[1], 0);
        end

        // Half amplitude: floor rounding on negative values
        do_reset();
        cfg_write(0, 0, 32'h40000000);
        cfg_write(0, 1, 16384);
        for (int b = 0; b < 4; b++) begin
            run_burst(2'b01, 0, -1, "half");
            check_val("half_ch0", last_out[0], e35[b]);
        end

        // Request while busy: single burst, sticky overrun
        run_burst(2'b11, 1, -1, "ovr");
        run_burst(2'b11, 0, -1, "ovr_hold");
        do_reset();
        @(negedge clk);
        check_val("ovr_clr", longint'(bus.overrun), 0);

        // Sweep clamps at sweep_end
        cfg_write(0, 0, 32'h01000000);
        cfg_write(0, 2, 32'h01000000);
        cfg_write(0, 3, 32'h03000000);
        cfg_write(0, 1, 20000);
        for (int b = 0; b < 5; b++) begin
            run_burst(2'b01, 0, -1, "sweep");
            cfg_read_check(0, 0, "sweep_inc");
            check_val("sweep_const", longint'(bus.cfg_rdata), e37[b]);
        end

        // Host write to inc wins over the sweep in the same cycle
        cfg_write(0, 0, 32'h00100000);
        cfg_write(0, 2, 32'h00010000);
        run_burst(2'b11, 0, 32'h00ABC000, "wrwin");
        cfg_read_check(0, 0, "wrwin_inc");

        // Reset in the middle of a burst
        @(negedge clk);
        bus.ch_enable = 2'b11;
        bus.sample_en = 1'b1;
        @(negedge clk);
        bus.sample_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_val("rst_busy",  longint'(bus.busy), 0);
        check_val("rst_valid", longint'(bus.out_valid), 0);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        check_val("rst_after", longint'(bus.out_valid), 0);
        cfg_write(0, 1, 32768);
        run_burst(2'b01, 0, -1, "rst_resume");
        check_val("rst_resume_ch0", last_out[0], 101);

        // Randomized traffic
        do_reset();
        for (int it = 0; it < 40; it++) random_round();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tone_gen.md
TONE_GEN -- requirements
Module: tone_gen

Interface
REQ-001 Parameter CHANNELS, default 2: number of independent tone channels (1..16).
REQ-002 Parameter PHASE_W, default 32: phase accumulator and increment width.
REQ-003 Parameter OUT_W, default 16: signed output sample width.
REQ-004 Parameter LUT_AW, default 8: quarter-wave table address width (2^LUT_AW entries).
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 sample_en  in  1  one-cycle request to produce one sample per channel.
REQ-008 cfg_we  in  1  config write strobe.
REQ-009 cfg_ch  in  max(1,$clog2(CHANNELS))  target channel.
REQ-010 cfg_addr  in  2  register select: 0=inc, 1=amp, 2=sweep_step, 3=sweep_end.
REQ-011 cfg_wdata  in  PHASE_W  write data; amp uses bits [15:0].
REQ-012 cfg_rdata  out  PHASE_W  registered readback of (cfg_ch, cfg_addr), 1-cycle latency.
REQ-013 ch_enable  in  CHANNELS  per-channel enable.
REQ-014 out_valid  out  1  out_data/out_ch valid this cycle.
REQ-015 out_ch  out  max(1,$clog2(CHANNELS))  channel of out_data.
REQ-016 out_data  out  OUT_W  signed sample.
REQ-017 busy  out  1  burst in progress.
REQ-018 overrun  out  1  sticky: sample_en arrived while busy.

Function
REQ-019 Per channel: phase, inc, amp, sweep_step, sweep_end registers (PHASE_W bits each; amp 16 bits).
REQ-020 sample_en at cycle T with busy low is accepted; busy high from T+1 through the cycle of the last out_valid.
REQ-021 Channels are processed in ascending order, one per cycle; out_valid for channel c asserts at T+3+c, exactly one cycle each.
REQ-022 Stage 1: read phase p; quadrant q=p[PHASE_W-1:PHASE_W-2]; idx=p[PHASE_W-3 -: LUT_AW]; idx inverted when q is 1 or 3.
REQ-023 Stage 2: LUT[k]=round((2^(OUT_W-1)-1)*sin(pi/2*(k+0.5)/2^LUT_AW)); value negated when q is 2 or 3.
REQ-024 Stage 3: out_data=(s*a)>>>15, arithmetic shift (floor), a=min(amp,32768); no saturation needed.
REQ-025 Sample uses pre-update phase; after lookup, phase<=phase+inc modulo 2^PHASE_W.
REQ-026 Sweep when sweep_step!=0: after each sample, inc<=min(inc+sweep_step, sweep_end); inc>=sweep_end leaves inc unchanged; carry-out clamps to sweep_end.
REQ-027 Channel with ch_enable low at its stage 1: out_data=0, out_valid still asserted, phase forced to 0, no sweep update.
REQ-028 sample_en while busy is ignored and sets overrun; overrun cleared only by reset.
REQ-029 Config write takes effect next cycle; a write to the channel in stage 1 that same cycle wins over the sweep update; phase is not writable.
REQ-030 cfg_rdata for addr 1 zero-extends amp; reads allowed at any time.

Reset
REQ-031 While reset high: all registers (phase, inc, amp, sweep_step, sweep_end) = 0; out_valid, busy, overrun, out_ch, out_data, cfg_rdata = 0.
REQ-032 Reset mid-burst aborts the burst; no out_valid in the cycle after reset deasserts.

Verification (CHANNELS=2, PHASE_W=32, OUT_W=16, LUT_AW=8)
REQ-033 Reset, then idle 10 cycles -> all outputs 0; cfg_rdata reads 0 for every register.
REQ-034 ch0 inc=0x40000000, amp=32768, ch_enable=01, four bursts -> ch0 out_data 101, 32767, -101, -32767; ch1 0 each burst; out_valid at T+3 and T+4.
REQ-035 As REQ-034 with amp=16384 -> 50, 16383, -51, -16384.
REQ-036 sample_en at T and again at T+2 -> single burst (two out_valid), overrun=1 held until reset.
REQ-037 ch0 inc=0x01000000, sweep_step=0x01000000, sweep_end=0x03000000, five bursts -> cfg_rdata(inc) 0x02000000, 0x03000000, 0x03000000, 0x03000000, 0x03000000.
REQ-038 reset asserted at T+3 of a burst -> busy, out_valid 0 from T+4; subsequent sample_en yields phase-0 sample 101 (ch0 reconfigured to amp=32768).
